firebird7_in_gate1_tessent_tdr_data_mux_ctrl: RTL and testbench

- IJTAG test data register that sits directly upstream of the w19 data mux and drives its select and ijtag data inputs.
- A (WIDTH+1)-bit shift/update register: the MSB is the mux select, the lower WIDTH bits are the ijtag data word.
- The capture path observes the mux output (data_out), so the scan chain can read back what the mux actually delivers.
- Sits on an SIB-gated IJTAG segment inside the gate1 instrument.

---
 rtl/firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv | 50 +++++
 tb/tb_firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv
// rtl/firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv - IJTAG TDR driving the w19 data mux select and data word
module firebird7_in_gate1_tessent_tdr_data_mux_ctrl #(
   parameter int unsigned      WIDTH        = 19,
   parameter logic [WIDTH-1:0] RESET_DATA   = '0,
   parameter logic             RESET_SELECT = 1'b0
) (
   input  logic             ijtag_tck,
   input  logic             ijtag_reset,
   input  logic             ijtag_sel,
   input  logic             ijtag_ce,
   input  logic             ijtag_se,
   input  logic             ijtag_ue,
   input  logic             ijtag_si,
   output logic             ijtag_so,
   input  logic [WIDTH-1:0] mux_data_observe,
   output logic             ijtag_select,
   output logic [WIDTH-1:0] ijtag_data_out
);

   // sr[WIDTH] is the mux select, sr[WIDTH-1:0] the ijtag data word
   logic [WIDTH:0] sr;
   logic [WIDTH:0] upd;

   // Shift/capture stage: capture reads back the select in force plus what the mux delivers
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         sr <= '0;
      end else if (ijtag_sel) begin
         if (ijtag_ce) begin
            sr <= {upd[WIDTH], mux_data_observe};
         end else if (ijtag_se) begin
            sr <= {ijtag_si, sr[WIDTH:1]};
         end
      end
   end

   // Update stage: loads the pre-edge shift contents, so mux inputs never see shifting bits
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         upd <= {RESET_SELECT, RESET_DATA};
      end else if (ijtag_sel && ijtag_ue) begin
         upd <= sr;
      end
   end

   assign ijtag_select   = upd[WIDTH];
   assign ijtag_data_out = upd[WIDTH-1:0];
   assign ijtag_so       = sr[0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv
// tb/tb_firebird7_in_gate1_tessent_tdr_data_mux_ctrl.sv - self-checking bench for the w19 mux control TDR
module tb_firebird7_in_gate1_tessent_tdr_data_mux_ctrl;

   logic        ijtag_tck;
   logic        ijtag_reset;
   logic        ijtag_sel;
   logic        ijtag_ce;
   logic        ijtag_se;
   logic        ijtag_ue;
   logic        ijtag_si;
   logic        ijtag_so;
   logic [18:0] mux_data_observe;
   logic        ijtag_select;
   logic [18:0] ijtag_data_out;

   int n_vec;
   int n_err;

   // Reference model: the chain and the update word held as 20-bit numbers
   logic [19:0] m_sr;
   logic [19:0] m_upd;

   firebird7_in_gate1_tessent_tdr_data_mux_ctrl #(
      .WIDTH(19),
      .RESET_DATA(19'h0),
      .RESET_SELECT(1'b0)
   ) dut (
      .ijtag_tck(ijtag_tck),
      .ijtag_reset(ijtag_reset),
      .ijtag_sel(ijtag_sel),
      .ijtag_ce(ijtag_ce),
      .ijtag_se(ijtag_se),
      .ijtag_ue(ijtag_ue),
      .ijtag_si(ijtag_si),
      .ijtag_so(ijtag_so),
      .mux_data_observe(mux_data_observe),
      .ijtag_select(ijtag_select),
      .ijtag_data_out(ijtag_data_out)
   );

   initial ijtag_tck = 1'b0;
   always #5 ijtag_tck = ~ijtag_tck;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one cycle of inputs, advance one rising edge, update the model, settle 1 ns
   task automatic tick(input logic a_sel, input logic a_ce, input logic a_se,
                       input logic a_ue, input logic a_si, input logic [18:0] a_obs);
      logic [19:0] nsr;
      ijtag_sel        = a_sel;
      ijtag_ce         = a_ce;
      ijtag_se         = a_se;
      ijtag_ue         = a_ue;
      ijtag_si         = a_si;
      mux_data_observe = a_obs;
      @(posedge ijtag_tck);
      if (ijtag_reset && a_sel) begin
         nsr = m_sr;
         if (a_ce)
            nsr = (m_upd & 20'h80000) + {1'b0, a_obs};
         else if (a_se)
            nsr = m_sr / 2 + (a_si ? 20'h80000 : 20'h0);
         if (a_ue)
            m_upd = m_sr;
         m_sr = nsr;
      end
      #1;
   endtask

   task automatic test_reset();
      ijtag_reset = 1'b0;
      m_sr = '0;
      m_upd = '0;
      #2;
      n_vec++;
      if (ijtag_select !== 1'b0) begin n_err++; $display("FAIL reset_select: got %b want 0", ijtag_select); end
      n_vec++;
      if (ijtag_data_out !== 19'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000", ijtag_data_out); end
      n_vec++;
      if (ijtag_so !== 1'b0) begin n_err++; $display("FAIL reset_so: got %b want 0", ijtag_so); end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 19'h7FFFF);
         n_vec++;
         if ({ijtag_select, ijtag_data_out, ijtag_so} !== 21'h0) begin
            n_err++;
            $display("FAIL reset_hold: got sel=%b data=%h so=%b want all 0", ijtag_select, ijtag_data_out, ijtag_so);
         end
      end
      #2;
      ijtag_reset = 1'b1;
   endtask

   task automatic test_shift_update();
      logic [19:0] v;
      v = 20'h80000 + 20'h5A5A5;
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0, v[i], 19'h0);
         n_vec++;
         if ({ijtag_select, ijtag_data_out} !== 20'h0) begin
            n_err++;
            $display("FAIL shift_glitch: got %h want 00000", {ijtag_select, ijtag_data_out});
         end
      end
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 19'h0);
      n_vec++;
      if (ijtag_select !== 1'b1) begin n_err++; $display("FAIL update_select: got %b want 1", ijtag_select); end
      n_vec++;
      if (ijtag_data_out !== 19'h5A5A5) begin n_err++; $display("FAIL update_data: got %h want 5a5a5", ijtag_data_out); end
   endtask

   task automatic test_capture_readback();
      logic [19:0] e;
      e = 20'hFFFFF;
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h7FFFF);
      for (int i = 0; i < 20; i++) begin
         n_vec++;
         if (ijtag_so !== e[i]) begin n_err++; $display("FAIL capture_bit%0d: got %b want %b", i, ijtag_so, e[i]); end
         tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19'h0);
      end
   endtask

   task automatic test_deselected_hold();
      logic [19:0] p;
      logic [19:0] outs;
      logic        so0;
      p = 20'($urandom);
      for (int i = 0; i < 20; i++)
         tick(1'b1, 1'b0, 1'b1, 1'b0, p[i], 19'h0);
      outs = {ijtag_select, ijtag_data_out};
      so0  = ijtag_so;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, i[0], 1'b1, ~i[0], i[1], 19'($urandom));
         n_vec++;
         if ({ijtag_select, ijtag_data_out, ijtag_so} !== {outs, so0}) begin
            n_err++;
            $display("FAIL desel_hold: got %h/%b want %h/%b", {ijtag_select, ijtag_data_out}, ijtag_so, outs, so0);
         end
      end
      for (int i = 0; i < 20; i++) begin
         n_vec++;
         if (ijtag_so !== p[i]) begin n_err++; $display("FAIL desel_chain_bit%0d: got %b want %b", i, ijtag_so, p[i]); end
         tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19'h0);
      end
   endtask

   task automatic test_update_and_shift();
      logic [19:0] pre;
      logic [19:0] e;
      pre = 20'h00123;
      for (int i = 0; i < 20; i++)
         tick(1'b1, 1'b0, 1'b1, 1'b0, pre[i], 19'h0);
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 19'h0);
      n_vec++;
      if ({ijtag_select, ijtag_data_out} !== 20'h00123) begin
         n_err++;
         $display("FAIL upd_shift_upd: got %h want 00123", {ijtag_select, ijtag_data_out});
      end
      e = 20'h80000 + pre / 2;
      for (int i = 0; i < 20; i++) begin
         n_vec++;
         if (ijtag_so !== e[i]) begin n_err++; $display("FAIL upd_shift_sr_bit%0d: got %b want %b", i, ijtag_so, e[i]); end
         tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19'h0);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [19:0] v;
      v = 20'h80000 + 20'h1ABCD;
      for (int i = 0; i < 10; i++)
         tick(1'b1, 1'b0, 1'b1, 1'b0, v[i], 19'h0);
      #2;
      ijtag_reset = 1'b0;
      m_sr = '0;
      m_upd = '0;
      #1;
      n_vec++;
      if ({ijtag_select, ijtag_data_out, ijtag_so} !== 21'h0) begin
         n_err++;
         $display("FAIL midreset: got sel=%b data=%h so=%b want all 0", ijtag_select, ijtag_data_out, ijtag_so);
      end
      ijtag_reset = 1'b1;
      v = 20'h80001;
      for (int i = 0; i < 20; i++)
         tick(1'b1, 1'b0, 1'b1, 1'b0, v[i], 19'h0);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 19'h0);
      n_vec++;
      if (ijtag_select !== 1'b1) begin n_err++; $display("FAIL midreset_select: got %b want 1", ijtag_select); end
      n_vec++;
      if (ijtag_data_out !== 19'h00001) begin n_err++; $display("FAIL midreset_data: got %h want 00001", ijtag_data_out); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            #2;
            ijtag_reset = 1'b0;
            m_sr = '0;
            m_upd = '0;
            #1;
            ijtag_reset = 1'b1;
         end
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom),
              $urandom_range(0, 3) == 0, 1'($urandom), 19'($urandom));
         n_vec++;
         if (ijtag_so !== m_sr[0]) begin n_err++; $display("FAIL rand_so@%0d: got %b want %b", i, ijtag_so, m_sr[0]); end
         n_vec++;
         if ({ijtag_select, ijtag_data_out} !== m_upd) begin
            n_err++;
            $display("FAIL rand_upd@%0d: got %h want %h", i, {ijtag_select, ijtag_data_out}, m_upd);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      ijtag_sel = 1'b0;
      ijtag_ce = 1'b0;
      ijtag_se = 1'b0;
      ijtag_ue = 1'b0;
      ijtag_si = 1'b0;
      mux_data_observe = '0;
      test_reset();
      test_shift_update();
      test_capture_readback();
      test_deselected_hold();
      test_update_and_shift();
      test_reset_mid_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
